// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register: operation codes and burst FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    SHL   = 3'd1,
    SHR   = 3'd2,
    ROL   = 3'd3,
    ROR   = 3'd4,
    ASR   = 3'd5,
    LOAD  = 3'd6,
    CLEAR = 3'd7
  } usr_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } usr_state_t;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of one serial channel; master drives commands, slave returns state.
interface univ_shift_reg_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
);
  logic             en;
  logic [2:0]       mode;
  logic             sin;
  logic [WIDTH-1:0] pdin;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, sin, pdin, start, count,
    input  q, sout, busy, done
  );

  modport slave (
    input  en, mode, sin, pdin, start, count,
    output q, sout, busy, done
  );
endinterface

// File: rtl/univ_shift_reg_op_unit.sv
// Combinational next-q / next-sout for a single shift-register operation.
module usr_op_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             sout_i,
  input  logic             sin_i,
  input  logic [WIDTH-1:0] pdin_i,
  input  usr_mode_t        mode_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_o
);

  always_comb begin
    q_o    = q_i;
    sout_o = sout_i;
    unique case (mode_i)
      HOLD: ;
      SHL: begin
        q_o    = {q_i[WIDTH-2:0], sin_i};
        sout_o = q_i[WIDTH-1];
      end
      SHR: begin
        q_o    = {sin_i, q_i[WIDTH-1:1]};
        sout_o = q_i[0];
      end
      ROL: begin
        q_o    = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        sout_o = q_i[WIDTH-1];
      end
      ROR: begin
        q_o    = {q_i[0], q_i[WIDTH-1:1]};
        sout_o = q_i[0];
      end
      ASR: begin
        q_o    = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        sout_o = q_i[0];
      end
      LOAD:  q_o = pdin_i;
      CLEAR: begin
        q_o    = '0;
        sout_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with direct operations and a counted burst engine.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input logic              clk,
  input logic              r,
  univ_shift_reg_if.slave  bus
);

  usr_state_t       state_q, state_d;
  usr_mode_t        mode_l_q, mode_l_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;

  usr_mode_t        op_mode;
  logic             do_op;
  logic [WIDTH-1:0] op_q;
  logic             op_sout;

  always_ff @(posedge clk) begin
    if (!r) begin
      state_q  <= IDLE;
      mode_l_q <= HOLD;
      cnt_q    <= '0;
      q_q      <= '0;
      sout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_l_q <= mode_l_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      sout_q   <= sout_d;
    end
  end

  // DONE accepts a new start just like IDLE, which allows back-to-back bursts.
  always_comb begin
    state_d  = state_q;
    mode_l_d = mode_l_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      RUN: begin
        if (bus.en) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        if (bus.start) begin
          mode_l_d = usr_mode_t'(bus.mode);
          cnt_d    = bus.count;
          state_d  = (bus.count != '0) ? RUN : DONE;
        end
      end
    endcase
  end

  // Bursts replay the latched mode; the start cycle itself never executes an op.
  always_comb begin
    op_mode = usr_mode_t'(bus.mode);
    do_op   = bus.en && !bus.start;
    if (state_q == RUN) begin
      op_mode = mode_l_q;
      do_op   = bus.en;
    end
  end

  usr_op_unit #(.WIDTH(WIDTH)) u_op (
    .q_i    (q_q),
    .sout_i (sout_q),
    .sin_i  (bus.sin),
    .pdin_i (bus.pdin),
    .mode_i (op_mode),
    .q_o    (op_q),
    .sout_o (op_sout)
  );

  assign q_d    = do_op ? op_q : q_q;
  assign sout_d = do_op ? op_sout : sout_q;

  assign bus.q    = q_q;
  assign bus.sout = sout_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);

endmodule
